cook_sequencer: RTL

//  Top-level microwave cooking controller; sequences the BCD down-counter chain (sec-units, sec-tens, min).

---
 rtl/cook_sequencer_if.sv | 26 ++
 rtl/cook_sequencer.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/cook_sequencer_if.sv
// cook_sequencer_if: keypad/door inputs and counter-chain controls
// between the cooking sequencer and its surroundings.
interface cook_sequencer_if;
    logic        key_valid;
    logic [3:0]  key_digit;
    logic        start;
    logic        stop;
    logic        door_open;
    logic        timer_zero;
    logic [11:0] preset;
    logic        load_n;
    logic        count_en;
    logic        mag_on;
    logic        beep;
    logic [2:0]  state;

    modport master (
        output key_valid, key_digit, start, stop, door_open, timer_zero,
        input  preset, load_n, count_en, mag_on, beep, state
    );

    modport slave (
        input  key_valid, key_digit, start, stop, door_open, timer_zero,
        output preset, load_n, count_en, mag_on, beep, state
    );
endinterface

// File: rtl/cook_sequencer.sv
// cook_sequencer: microwave cooking controller. Collects an M:SS preset,
// loads the BCD counter chain, paces it at 1 Hz and drives magnetron/beeper.
module cook_sequencer #(
    parameter int TICK_DIV    = 50_000_000,
    parameter int BEEP_CYCLES = 3
) (
    input  logic            clk,
    input  logic            clrn,
    cook_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ENTRY = 3'd1,
        S_LOAD  = 3'd2,
        S_COOK  = 3'd3,
        S_PAUSE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam int PW = $clog2(TICK_DIV);
    localparam int BW = (BEEP_CYCLES < 2) ? 1 : $clog2(BEEP_CYCLES + 1);
    localparam logic [PW-1:0] P_TOP  = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] B_LAST = BW'(BEEP_CYCLES - 1);

    state_t        r_state;
    state_t        w_next;
    logic [11:0]   r_preset;
    logic [11:0]   w_preset_n;
    logic [PW-1:0] r_presc;
    logic [PW-1:0] w_presc_n;
    logic [PW-1:0] w_presc_inc;
    logic [BW-1:0] r_bcnt;
    logic [BW-1:0] w_bcnt_n;
    logic          r_load_n;
    logic          r_count_en;
    logic          r_mag_on;
    logic          r_beep;
    logic          w_key_ok;
    logic          w_tens_ok;
    logic          w_wrap;

    assign w_key_ok    = bus.key_valid && (bus.key_digit <= 4'd9);
    // The old sec_units digit becomes sec_tens after the shift.
    assign w_tens_ok   = (r_preset[3:0] <= 4'd5);
    assign w_wrap      = (r_presc == P_TOP);
    assign w_presc_inc = w_wrap ? '0 : r_presc + 1'b1;

    // State register.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next state, next preset, prescaler and beep counter.
    always_comb begin
        w_next     = r_state;
        w_preset_n = r_preset;
        w_presc_n  = r_presc;
        w_bcnt_n   = r_bcnt;
        unique case (r_state)
            S_IDLE: begin
                if (w_key_ok) begin
                    w_preset_n = {8'h00, bus.key_digit};
                    w_next     = S_ENTRY;
                end
            end
            S_ENTRY: begin
                if (bus.stop) begin
                    w_preset_n = '0;
                    w_next     = S_IDLE;
                end else if (bus.start) begin
                    if (!bus.door_open && r_preset != 12'h000)
                        w_next = S_LOAD;
                end else if (w_key_ok && w_tens_ok) begin
                    w_preset_n = {r_preset[7:0], bus.key_digit};
                end
            end
            S_LOAD: begin
                w_presc_n = '0;
                w_next    = S_COOK;
            end
            S_COOK: begin
                if (bus.timer_zero) begin
                    w_presc_n = '0;
                    w_bcnt_n  = '0;
                    w_next    = S_DONE;
                end else if (bus.door_open || bus.stop) begin
                    // A tick already issued this cycle is not repeated on resume.
                    w_presc_n = w_wrap ? '0 : r_presc;
                    w_next    = S_PAUSE;
                end else begin
                    w_presc_n = w_presc_inc;
                end
            end
            S_PAUSE: begin
                if (bus.stop) begin
                    w_preset_n = '0;
                    w_next     = S_IDLE;
                end else if (bus.start && !bus.door_open) begin
                    w_next = S_COOK;
                end
            end
            S_DONE: begin
                if (bus.stop || w_key_ok) begin
                    w_next = S_IDLE;
                end else begin
                    w_presc_n = w_presc_inc;
                    if (w_wrap) begin
                        if (r_bcnt == B_LAST) w_next = S_IDLE;
                        else w_bcnt_n = r_bcnt + 1'b1;
                    end
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath and registered outputs, all decided from the next state.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_preset   <= '0;
            r_presc    <= '0;
            r_bcnt     <= '0;
            r_load_n   <= 1'b1;
            r_count_en <= 1'b0;
            r_mag_on   <= 1'b0;
            r_beep     <= 1'b0;
        end else begin
            r_preset   <= w_preset_n;
            r_presc    <= w_presc_n;
            r_bcnt     <= w_bcnt_n;
            r_load_n   <= (w_next != S_LOAD);
            r_count_en <= (w_next == S_COOK) && (w_presc_n == P_TOP);
            r_mag_on   <= (w_next == S_COOK);
            r_beep     <= (w_next == S_DONE);
        end
    end

    assign bus.preset   = r_preset;
    assign bus.load_n   = r_load_n;
    assign bus.count_en = r_count_en;
    assign bus.mag_on   = r_mag_on;
    assign bus.beep     = r_beep;
    assign bus.state    = r_state;
endmodule
